// File: rtl/crc_frame_tx.sv
// CRC-32 framing stage: passes one payload word to the CRC generator, then
// serializes {payload, crc} MSB-first on a 1-bit valid/ready stream.
module crc_frame_tx #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             crc_rd,
    output logic [WIDTH-1:0] crc_data,
    input  logic [WIDTH-1:0] crc_value,
    input  logic             crc_ready,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic             busy,
    output logic             timeout_err
);
    localparam int unsigned FW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(FW);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, CALC, SEND} state_e;

    state_e         state_q, state_d;
    logic [WIDTH-1:0] payload_q, payload_d;
    logic [FW-1:0]  shift_q, shift_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           crc_rd_q, crc_rd_d;
    logic           ser_valid_q, ser_valid_d;
    logic           ser_last_q, ser_last_d;
    logic           err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            payload_q   <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            crc_rd_q    <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            payload_q   <= payload_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            crc_rd_q    <= crc_rd_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        payload_d   = payload_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        crc_rd_d    = 1'b0;
        ser_valid_d = ser_valid_q;
        ser_last_d  = ser_last_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    payload_d = in_data;
                    err_d     = 1'b0;
                    crc_rd_d  = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // crc_ready during the request cycle belongs to an older result
                timer_d = '0;
                state_d = CALC;
            end
            CALC: begin
                timer_d = timer_q + 1'b1;
                if (crc_ready) begin
                    shift_d     = {payload_q, crc_value};
                    cnt_d       = CW'(FW - 1);
                    ser_valid_d = 1'b1;
                    ser_last_d  = 1'b0;
                    state_d     = SEND;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (ser_valid_q && ser_ready) begin
                    shift_d    = {shift_q[FW-2:0], 1'b0};
                    cnt_d      = cnt_q - 1'b1;
                    ser_last_d = (cnt_q == CW'(1));
                    if (ser_last_q) begin
                        cnt_d       = '0;
                        ser_valid_d = 1'b0;
                        ser_last_d  = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign crc_rd      = crc_rd_q;
    assign crc_data    = payload_q;
    assign ser_valid   = ser_valid_q;
    assign ser_bit     = shift_q[FW-1];
    assign ser_last    = ser_last_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Self-checking bench for crc_frame_tx: a bench-side CRC generator model pushes
// the expected frame bits to a queue, popped on every serial handshake.
module tb_crc_frame_tx;
    localparam int unsigned W  = 32;
    localparam int          TO = 64;

    logic         clk = 1'b0, rst = 1'b0;
    logic         in_valid = 1'b0, crc_ready = 1'b0, ser_ready = 1'b1;
    logic [W-1:0] in_data = '0, crc_value = '0;
    logic         in_ready, crc_rd, ser_valid, ser_bit, ser_last, busy, timeout_err;
    logic [W-1:0] crc_data;

    int checks = 0, errors = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    crc_frame_tx #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .crc_rd(crc_rd), .crc_data(crc_data), .crc_value(crc_value), .crc_ready(crc_ready),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_bit(ser_bit), .ser_last(ser_last),
        .busy(busy), .timeout_err(timeout_err)
    );

    // Runs one frame; crc_ready pulses n cycles after the crc_rd cycle.
    task automatic run_frame(input logic [W-1:0] pay, input logic [W-1:0] crc, input int n,
                             input bit bp, input bit stale, input int stop_after, input string tag);
        logic [2*W-1:0] frame;
        int  cyc, nbits, first, lastc, p;
        bit  done, held, hb, hl, rdy, eb;
        frame = {pay, crc};
        cyc = 0; nbits = 0; first = -1; lastc = -1; p = 0; done = 0; held = 0; hb = 0; hl = 0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready_idle: got %b want 1", tag, in_ready); end
        in_valid = 1'b1; in_data = pay;
        @(negedge clk); cyc = 1;
        in_valid = 1'b0; in_data = ~pay;
        checks++; if (crc_rd !== 1'b1) begin errors++; $display("FAIL %s crc_rd_pulse: got %b want 1", tag, crc_rd); end
        checks++; if (crc_data !== pay) begin errors++; $display("FAIL %s crc_data: got %h want %h", tag, crc_data, pay); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL %s err_clear: got %b want 0", tag, timeout_err); end
        crc_ready = stale;
        crc_value = stale ? 32'hDEADBEEF : '0;
        while (!done && cyc < 600) begin
            @(negedge clk); cyc++;
            crc_ready = 1'b0;
            if (cyc == 2) begin
                checks++; if (crc_rd !== 1'b0) begin errors++; $display("FAIL %s crc_rd_single: got %b want 0", tag, crc_rd); end
            end
            if (cyc == 1 + n) begin
                checks++; if (crc_data !== pay) begin errors++; $display("FAIL %s crc_data_hold: got %h want %h", tag, crc_data, pay); end
                crc_ready = 1'b1; crc_value = crc;
                for (int i = 2*W-1; i >= 0; i--) exp_q.push_back(frame[i]);
            end
            if (ser_valid) begin
                if (first < 0) first = cyc;
                if (held) begin
                    checks++;
                    if (ser_bit !== hb || ser_last !== hl) begin
                        errors++; $display("FAIL %s hold_stable: got bit=%b last=%b want bit=%b last=%b", tag, ser_bit, ser_last, hb, hl);
                    end
                end
                rdy = bp ? (p % 4 == 0 || p % 4 == 3) : 1'b1;
                p++;
                ser_ready = rdy;
                held = !rdy; hb = ser_bit; hl = ser_last;
                if (rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++; done = 1;
                        $display("FAIL %s extra_bit: got ser_valid=1 want 0 (no frame pending)", tag);
                    end else begin
                        eb = exp_q.pop_front();
                        nbits++; lastc = cyc;
                        checks++;
                        if (ser_bit !== eb || ser_last !== (exp_q.size() == 0)) begin
                            errors++; $display("FAIL %s bit%0d: got bit=%b last=%b want bit=%b last=%b",
                                               tag, nbits, ser_bit, ser_last, eb, exp_q.size() == 0);
                        end
                        if (ser_last || exp_q.size() == 0) done = 1;
                        if (stop_after > 0 && nbits == stop_after) return;
                    end
                end
            end else begin
                ser_ready = 1'b1;
            end
        end
        ser_ready = 1'b1;
        checks++; if (!done) begin errors++; $display("FAIL %s frame_timeout: got no end within %0d cycles want frame end", tag, cyc); end
        checks++; if (nbits != 2*W) begin errors++; $display("FAIL %s bit_count: got %0d want %0d", tag, nbits, 2*W); end
        if (!bp) begin
            checks++; if (first != n + 2) begin errors++; $display("FAIL %s first_latency: got %0d want %0d", tag, first, n + 2); end
            checks++; if (lastc - first != 2*W - 1) begin errors++; $display("FAIL %s frame_span: got %0d want %0d", tag, lastc - first, 2*W - 1); end
        end
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (ser_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL %s post_frame: got valid=%b in_ready=%b busy=%b err=%b want 0 1 0 0",
                               tag, ser_valid, in_ready, busy, timeout_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || crc_rd !== 1'b0 || crc_data !== '0 || ser_valid !== 1'b0 ||
            ser_bit !== 1'b0 || ser_last !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_state: got in_ready=%b crc_rd=%b crc_data=%h valid=%b bit=%b last=%b busy=%b err=%b want 1 0 0 0 0 0 0 0",
                               in_ready, crc_rd, crc_data, ser_valid, ser_bit, ser_last, busy, timeout_err);
        end
        in_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        run_frame(32'h12345678, 32'hCBF43926, 33, 1'b0, 1'b0, 0, "basic");
    endtask

    task automatic test_backpressure();
        run_frame(32'h12345678, 32'hCBF43926, 33, 1'b1, 1'b0, 0, "backpressure");
    endtask

    task automatic test_stale_ready();
        run_frame(32'h0BADF00D, 32'hA5A5A5A5, 5, 1'b0, 1'b1, 0, "stale");
    endtask

    task automatic test_timeout();
        int cyc, hit;
        bit sv_seen;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hCAFEF00D; crc_ready = 1'b0;
        @(negedge clk); cyc = 1; in_valid = 1'b0; hit = -1; sv_seen = 0;
        while (hit < 0 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (ser_valid) sv_seen = 1;
            if (timeout_err) hit = cyc;
        end
        checks++; if (hit != TO + 2) begin errors++; $display("FAIL timeout_cycle: got %0d want %0d", hit, TO + 2); end
        checks++; if (sv_seen) begin errors++; $display("FAIL timeout_no_bits: got ser_valid=1 want 0"); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle: got busy=%b in_ready=%b want 0 1", busy, in_ready); end
        run_frame(32'h55AA33CC, 32'h0F0F0F0F, 7, 1'b0, 1'b0, 0, "after_timeout");
    endtask

    task automatic test_tie_break();
        run_frame(32'h87654321, 32'h13579BDF, TO, 1'b0, 1'b0, 0, "tie_break");
    endtask

    task automatic test_reset_midframe();
        run_frame(32'h0F1E2D3C, 32'h89ABCDEF, 3, 1'b0, 1'b0, 20, "rst_mid");
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        exp_q.delete();
        checks++;
        if (ser_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || crc_data !== '0 || ser_last !== 1'b0) begin
            errors++; $display("FAIL rst_mid_state: got valid=%b busy=%b in_ready=%b crc_data=%h last=%b want 0 0 1 0 0",
                               ser_valid, busy, in_ready, crc_data, ser_last);
        end
        run_frame(32'hFEDCBA98, 32'h76543210, 2, 1'b0, 1'b0, 0, "rst_fresh");
    endtask

    task automatic test_back_to_back();
        run_frame(32'hFFFFFFFF, 32'h00000001, 1, 1'b0, 1'b0, 0, "b2b_a");
        run_frame(32'h80000000, 32'hFFFFFFFE, 1, 1'b1, 1'b0, 0, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stale_ready();
        test_timeout();
        test_tie_break();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
